// File: rtl/bcd_scan_display.sv
// 8-bit binary to 3-digit BCD converter (shift-add-3) driving a multiplexed,
// active-low 7-segment display with optional leading-zero blanking.
module bcd_scan_display #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter bit          BLANK    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_a,
    input  logic [7:0] valor,
    input  logic       load,
    output logic       busy,
    output logic [6:0] seg,
    output logic [2:0] an
);

    localparam int unsigned          PRE_W    = $clog2(SCAN_DIV);
    localparam logic [PRE_W-1:0]     PRE_LAST = PRE_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt_q, cnt_nxt;
    logic [7:0]  bin_q, bin_nxt;
    logic [11:0] bcd_q, bcd_nxt;
    logic [11:0] adjusted;
    logic [19:0] shifted;
    logic        disp_we;

    logic [3:0]  hund, tens, units;
    logic [PRE_W-1:0] pre_q;
    logic [1:0]  idx_q;

    logic [3:0]  nib;
    logic        blank_digit;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Converter next-state: one double-dabble step per SHIFT cycle
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_q;
        bin_nxt   = bin_q;
        bcd_nxt   = bcd_q;
        disp_we   = 1'b0;
        adjusted  = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
        shifted   = {adjusted, bin_q} << 1;
        case (state)
            IDLE: begin
                if (load) begin
                    bin_nxt   = valor;
                    bcd_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                bcd_nxt = shifted[19:8];
                bin_nxt = shifted[7:0];
                cnt_nxt = cnt_q + 4'd1;
                if (cnt_q == 4'd7) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                disp_we   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            state <= IDLE;
            cnt_q <= '0;
        end else begin
            state <= state_nxt;
            cnt_q <= cnt_nxt;
        end
    end

    // Working registers carry no reset: they are always reloaded on load
    always_ff @(posedge clk) begin
        bin_q <= bin_nxt;
        bcd_q <= bcd_nxt;
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            hund  <= '0;
            tens  <= '0;
            units <= '0;
        end else if (disp_we) begin
            hund  <= bcd_q[11:8];
            tens  <= bcd_q[7:4];
            units <= bcd_q[3:0];
        end
    end

    // Scan prescaler and digit index run regardless of converter state
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            pre_q <= '0;
            idx_q <= 2'd0;
        end else if (pre_q == PRE_LAST) begin
            pre_q <= '0;
            idx_q <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

    assign busy = (state != IDLE);

    always_comb begin
        nib         = units;
        blank_digit = 1'b0;
        an          = 3'b110;
        case (idx_q)
            2'd1: begin
                nib         = tens;
                blank_digit = BLANK && (hund == 4'd0) && (tens == 4'd0);
                an          = 3'b101;
            end
            2'd2: begin
                nib         = hund;
                blank_digit = BLANK && (hund == 4'd0);
                an          = 3'b011;
            end
            default: begin
                nib         = units;
                blank_digit = 1'b0;
                an          = 3'b110;
            end
        endcase
        seg = blank_digit ? 7'b1111111 : seg_decode(nib);
    end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display: reset, conversions, blanking, ignored
// load, abort and an exhaustive sweep of all 256 input values.
module tb_bcd_scan_display;

    logic       clk     = 1'b0;
    logic       clk_run = 1'b0;
    logic       rst_a   = 1'b1;
    logic [7:0] valor   = 8'd0;
    logic       load    = 1'b0;

    logic       busy_b, busy_n;
    logic [6:0] seg_b, seg_n;
    logic [2:0] an_b, an_n;
    logic [11:0] disp_b;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_scan_display #(.SCAN_DIV(4), .BLANK(1'b1)) dut (
        .clk(clk), .rst_a(rst_a), .valor(valor), .load(load),
        .busy(busy_b), .seg(seg_b), .an(an_b)
    );

    bcd_scan_display #(.SCAN_DIV(4), .BLANK(1'b0)) dut_nb (
        .clk(clk), .rst_a(rst_a), .valor(valor), .load(load),
        .busy(busy_n), .seg(seg_n), .an(an_n)
    );

    assign disp_b = {dut.hund, dut.tens, dut.units};

    initial begin
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_conversion(input logic [7:0] v, output int cyc);
        valor = v;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        cyc   = 0;
        while (busy_b && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    task automatic wait_slot(input logic [2:0] pat, output bit found);
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            if (an_b == pat) found = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        #2 rst_a = 1'b0;
        #1;
        n_checks++;
        if (an_b !== 3'b110) begin
            n_fail++; $display("FAIL reset_an: got %b expected 110", an_b);
        end
        n_checks++;
        if (seg_b !== 7'b1000000) begin
            n_fail++; $display("FAIL reset_seg: got %b expected 1000000", seg_b);
        end
        n_checks++;
        if (busy_b !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_b);
        end
        n_checks++;
        if (disp_b !== 12'h000) begin
            n_fail++; $display("FAIL reset_disp: got %h expected 000", disp_b);
        end
    endtask

    task automatic test_conv_255();
        bit busy_ok;
        bit found;
        valor = 8'd255;
        load  = 1'b1;
        #1 rst_a = 1'b1;
        clk_run = 1'b1;
        tick();
        load = 1'b0;
        n_checks++;
        if (busy_b !== 1'b1) begin
            n_fail++; $display("FAIL first_edge_busy: got %b expected 1", busy_b);
        end
        busy_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (busy_b !== 1'b1) busy_ok = 1'b0;
        end
        n_checks++;
        if (busy_ok !== 1'b1) begin
            n_fail++; $display("FAIL busy_hold_255: got %b expected 1", busy_ok);
        end
        n_checks++;
        if (disp_b !== 12'h000) begin
            n_fail++; $display("FAIL disp_before_done: got %h expected 000", disp_b);
        end
        tick();
        n_checks++;
        if (busy_b !== 1'b0) begin
            n_fail++; $display("FAIL busy_fall_255: got %b expected 0", busy_b);
        end
        n_checks++;
        if (disp_b !== 12'h255) begin
            n_fail++; $display("FAIL disp_255: got %h expected 255", disp_b);
        end
        wait_slot(3'b110, found);
        n_checks++;
        if (!found || seg_b !== 7'b0010010) begin
            n_fail++; $display("FAIL seg_255_units: got %b (found %0d) expected 0010010", seg_b, found);
        end
        wait_slot(3'b101, found);
        n_checks++;
        if (!found || seg_b !== 7'b0010010) begin
            n_fail++; $display("FAIL seg_255_tens: got %b (found %0d) expected 0010010", seg_b, found);
        end
        wait_slot(3'b011, found);
        n_checks++;
        if (!found || seg_b !== 7'b0100100) begin
            n_fail++; $display("FAIL seg_255_hund: got %b (found %0d) expected 0100100", seg_b, found);
        end
    endtask

    task automatic test_blank_7();
        int cyc;
        bit found;
        bit bad_an;
        logic [2:0] prev;
        logic [2:0] exp_next;
        int period;
        run_conversion(8'd7, cyc);
        n_checks++;
        if (cyc != 9) begin
            n_fail++; $display("FAIL latency_7: got %0d expected 9", cyc);
        end
        n_checks++;
        if (disp_b !== 12'h007) begin
            n_fail++; $display("FAIL disp_7: got %h expected 007", disp_b);
        end
        wait_slot(3'b110, found);
        n_checks++;
        if (!found || seg_b !== 7'b1111000 || seg_n !== 7'b1111000) begin
            n_fail++; $display("FAIL seg_7_units: got %b/%b expected 1111000/1111000", seg_b, seg_n);
        end
        wait_slot(3'b101, found);
        n_checks++;
        if (!found || seg_b !== 7'b1111111 || seg_n !== 7'b1000000) begin
            n_fail++; $display("FAIL seg_7_tens: got %b/%b expected 1111111/1000000", seg_b, seg_n);
        end
        wait_slot(3'b011, found);
        n_checks++;
        if (!found || seg_b !== 7'b1111111 || seg_n !== 7'b1000000) begin
            n_fail++; $display("FAIL seg_7_hund: got %b/%b expected 1111111/1000000", seg_b, seg_n);
        end
        bad_an = 1'b0;
        prev = an_b;
        for (int i = 0; i < 8 && an_b == prev; i++) tick();
        prev = an_b;
        case (prev)
            3'b110:  exp_next = 3'b101;
            3'b101:  exp_next = 3'b011;
            default: exp_next = 3'b110;
        endcase
        period = 0;
        while (an_b == prev && period < 10) begin
            tick();
            period++;
            if (an_b != 3'b110 && an_b != 3'b101 && an_b != 3'b011) bad_an = 1'b1;
        end
        n_checks++;
        if (period != 4) begin
            n_fail++; $display("FAIL scan_period: got %0d expected 4", period);
        end
        n_checks++;
        if (an_b !== exp_next || bad_an) begin
            n_fail++; $display("FAIL scan_order: got %b expected %b", an_b, exp_next);
        end
    endtask

    task automatic test_ignored_load();
        bit found;
        valor = 8'd100;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        tick();
        tick();
        valor = 8'd42;
        load  = 1'b1;
        tick();
        n_checks++;
        if (busy_b !== 1'b1) begin
            n_fail++; $display("FAIL busy_n3: got %b expected 1", busy_b);
        end
        for (int i = 0; i < 5; i++) tick();
        n_checks++;
        if (disp_b !== 12'h007) begin
            n_fail++; $display("FAIL disp_hold_n8: got %h expected 007", disp_b);
        end
        tick();
        n_checks++;
        if (busy_b !== 1'b0 || disp_b !== 12'h100) begin
            n_fail++; $display("FAIL disp_100: got %h busy %b expected 100 busy 0", disp_b, busy_b);
        end
        tick();
        load  = 1'b0;
        valor = 8'd0;
        n_checks++;
        if (busy_b !== 1'b1) begin
            n_fail++; $display("FAIL busy_n10: got %b expected 1", busy_b);
        end
        for (int i = 0; i < 8; i++) tick();
        n_checks++;
        if (disp_b !== 12'h100) begin
            n_fail++; $display("FAIL disp_hold_n18: got %h expected 100", disp_b);
        end
        tick();
        n_checks++;
        if (busy_b !== 1'b0 || disp_b !== 12'h042) begin
            n_fail++; $display("FAIL disp_42: got %h busy %b expected 042 busy 0", disp_b, busy_b);
        end
        wait_slot(3'b101, found);
        n_checks++;
        if (!found || seg_b !== 7'b0011001) begin
            n_fail++; $display("FAIL seg_42_tens: got %b expected 0011001", seg_b);
        end
        wait_slot(3'b011, found);
        n_checks++;
        if (!found || seg_b !== 7'b1111111 || seg_n !== 7'b1000000) begin
            n_fail++; $display("FAIL seg_42_hund: got %b/%b expected 1111111/1000000", seg_b, seg_n);
        end
    endtask

    task automatic test_abort();
        int cyc;
        bit found;
        valor = 8'd200;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst_a = 1'b0;
        #1;
        n_checks++;
        if (busy_b !== 1'b0 || an_b !== 3'b110 || seg_b !== 7'b1000000) begin
            n_fail++; $display("FAIL abort_async: got busy %b an %b seg %b expected 0/110/1000000", busy_b, an_b, seg_b);
        end
        tick();
        rst_a = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        n_checks++;
        if (busy_b !== 1'b0 || disp_b !== 12'h000) begin
            n_fail++; $display("FAIL abort_disp: got %h busy %b expected 000 busy 0", disp_b, busy_b);
        end
        run_conversion(8'd200, cyc);
        n_checks++;
        if (cyc != 9 || disp_b !== 12'h200) begin
            n_fail++; $display("FAIL disp_200: got %h after %0d cycles expected 200 after 9", disp_b, cyc);
        end
        wait_slot(3'b101, found);
        n_checks++;
        if (!found || seg_b !== 7'b1000000) begin
            n_fail++; $display("FAIL seg_200_tens: got %b expected 1000000", seg_b);
        end
        wait_slot(3'b011, found);
        n_checks++;
        if (!found || seg_b !== 7'b0100100) begin
            n_fail++; $display("FAIL seg_200_hund: got %b expected 0100100", seg_b);
        end
    endtask

    task automatic test_exhaustive();
        int cyc;
        logic [11:0] exp_v;
        for (int v = 0; v < 256; v++) begin
            run_conversion(8'(v), cyc);
            exp_v = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            n_checks++;
            if (disp_b !== exp_v || cyc != 9) begin
                n_fail++;
                $display("FAIL sweep_%0d: got %h after %0d cycles expected %h after 9", v, disp_b, cyc, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_conv_255();
        test_blank_7();
        test_ignored_load();
        test_abort();
        test_exhaustive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_scan_display.md
BCD_SCAN_DISPLAY -- requirements
Module: bcd_scan_display

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000, clk cycles per digit slot (legal range 2..2^20).
REQ-002 The block SHALL have parameter BLANK, default 1, enabling leading-zero blanking when 1.
REQ-003 The block SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_a  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port valor  input  8  unsigned binary value to display (0..255), typically the counter output.
REQ-006 The block SHALL have port load  input  1  request to sample valor and start a conversion; a level, sampled each cycle.
REQ-007 The block SHALL have port busy  output  1  high while a conversion is in progress.
REQ-008 The block SHALL have port seg  output  7  active-low segments, seg[0]=a … seg[6]=g.
REQ-009 The block SHALL have port an  output  3  active-low digit enables: an[0]=units, an[1]=tens, an[2]=hundreds.

Function
REQ-010 The converter SHALL be an FSM with states IDLE, SHIFT and DONE.
REQ-011 In IDLE with load=1 at edge N, the block SHALL:
- capture valor into an 8-bit shift register;
- clear the 12-bit BCD accumulator and the 4-bit bit counter;
- enter SHIFT.
REQ-012 In SHIFT, each edge SHALL:
- add 3 to every BCD nibble ≥5 (shift-add-3 / double-dabble);
- shift {BCD, binary} left by one;
- increment the bit counter.
REQ-013 SHIFT SHALL occupy exactly 8 edges (N+1..N+8), then go to DONE.
REQ-014 DONE (edge N+9) SHALL copy the three BCD nibbles into display registers hund/tens/units in one cycle, then go to IDLE.
REQ-015 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE; it rises after edge N and falls after edge N+9.
REQ-016 load SHALL be ignored while busy=1; valor changes during a conversion SHALL NOT affect its result.
REQ-017 load held high SHALL start a new conversion on the first IDLE cycle, giving back-to-back conversions every 10 cycles.
REQ-018 Display registers SHALL change only in DONE; the display shows the previous value until then.
REQ-019 A prescaler SHALL count 0..SCAN_DIV-1 continuously, independent of converter state.
REQ-020 When the prescaler is at SCAN_DIV-1, the prescaler SHALL wrap to 0 and the digit index SHALL advance 0→1→2→0.
REQ-021 an SHALL be one-hot low from the digit index: idx0→3'b110, idx1→3'b101, idx2→3'b011; exactly one digit enabled at all times.
REQ-022 seg SHALL be the active-low decode of the indexed nibble: 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000.
REQ-023 With BLANK=1, the block SHALL drive seg=1111111 for hundreds when hund=0, and for tens when hund=0 and tens=0; units SHALL never be blanked.
REQ-024 With BLANK=0, all digits SHALL always be decoded.
REQ-025 Nibble codes 10..15 SHALL drive seg=1111111; they are unreachable by construction.
REQ-026 an and seg SHALL derive only from registered index and display registers, so they change together on the same edge.

Reset
REQ-027 While rst_a=0, the block SHALL immediately force:
- state=IDLE, busy=0;
- hund=tens=units=0;
- prescaler=0, idx=0;
- an=3'b110, seg=1000000 (units shows "0").
REQ-028 Reset asserted mid-conversion SHALL abort it; no display register update SHALL occur.
REQ-029 After rst_a rises, the first load SHALL be accepted on the first clk edge.

Verification
REQ-030 The bench SHALL cover reset: rst_a=0 asynchronously with clk stopped -> an=110, seg=1000000, busy=0.
REQ-031 The bench SHALL cover conversion 1: valor=8'd255, one-cycle load at edge N -> busy high edges N..N+9; after edge N+9 hund=2, tens=5, units=5; scanning shows 0010010 / 0010010 / 0100100 on an=110/101/011.
REQ-032 The bench SHALL cover conversion 2 with blanking: SCAN_DIV=4, BLANK=1, valor=8'd7 -> units shows 1111000; tens and hundreds slots show 1111111; index advances every 4 cycles.
REQ-033 The bench SHALL cover ignored load: valor=8'd100 loaded, then valor=8'd42 and load=1 at N+3 -> result 1,0,0; the second load is ignored; with load still high at N+10, 42 converts to 0,4,2 by edge N+19.
REQ-034 The bench SHALL cover abort: rst_a pulsed low at edge N+5 of converting 8'd200 -> displays stay 0,0,0 and busy=0; a subsequent load of 200 yields 2,0,0.
REQ-035 The bench SHALL cover exhaustive check: valor 0..255 each converted -> {hund,tens,units} equals valor/100, (valor/10)%10, valor%10.
